// File: rtl/trace_capture_buffer.sv
// Trace capture buffer: records one selected trace channel into a circular RAM around a
// trigger point, then freezes and is drained oldest-first one word per read request.
module trace_capture_buffer #(
  parameter int Fpay     = 32,
  parameter int TB_Depth = 512,
  parameter int CH       = 4,
  parameter int AW       = $clog2(TB_Depth),
  parameter int SW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH*Fpay-1:0] trace,
  input  logic [CH-1:0]     trace_valid,
  input  logic [SW-1:0]     ch_sel,
  input  logic [AW:0]       post_len,
  input  logic              arm,
  input  logic              trigger,
  input  logic              rd,
  output logic [Fpay-1:0]   dout,
  output logic              dout_valid,
  output logic              empty,
  output logic              wrapped,
  output logic [1:0]        state,
  output logic [AW:0]       count
);

  // state  | meaning
  // IDLE   | after reset, nothing recorded until arm
  // ARMED  | recording pre-trigger samples, waiting for trigger
  // POST   | recording the post-trigger window, trigger ignored
  // DONE   | buffer frozen, drained through rd
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH = (AW+1)'(TB_Depth);

  state_t            state_q;
  logic [Fpay-1:0]   mem [TB_Depth];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr_nxt;
  logic [SW-1:0]     sel_q;
  logic [AW:0]       post_len_q;
  logic [AW:0]       remain;
  logic [Fpay-1:0]   sample;
  logic              wr_en;
  logic              rd_en;
  logic              wrap_nxt;

  always_comb begin
    sample     = trace[int'(sel_q) * Fpay +: Fpay];
    wr_en      = !arm && (state_q == S_ARMED || state_q == S_POST) && trace_valid[sel_q];
    rd_en      = !arm && (state_q == S_DONE) && rd && (count != '0);
    wr_ptr_nxt = wr_en ? wr_ptr + 1'b1 : wr_ptr;
    // the write that lands on a full buffer discards the oldest entry
    wrap_nxt   = wrapped | (wr_en && (count == DEPTH));
  end

  // RAM has no reset: its contents are only meaningful through count
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wrapped    <= 1'b0;
      sel_q      <= '0;
      post_len_q <= '0;
      remain     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (arm) begin
        state_q    <= S_ARMED;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        wrapped    <= 1'b0;
        remain     <= '0;
        sel_q      <= ch_sel;
        post_len_q <= (post_len > DEPTH) ? DEPTH : post_len;
      end else begin
        if (wr_en) begin
          wr_ptr  <= wr_ptr_nxt;
          wrapped <= wrap_nxt;
          if (count != DEPTH) count <= count + 1'b1;
        end
        case (state_q)
          S_ARMED: begin
            if (trigger) begin
              if (post_len_q == '0) begin
                state_q <= S_DONE;
                rd_ptr  <= wrap_nxt ? wr_ptr_nxt : '0;
              end else begin
                state_q <= S_POST;
                remain  <= post_len_q;
              end
            end
          end
          S_POST: begin
            if (wr_en) begin
              remain <= remain - 1'b1;
              if (remain == (AW+1)'(1)) begin
                state_q <= S_DONE;
                rd_ptr  <= wrap_nxt ? wr_ptr_nxt : '0;
              end
            end
          end
          S_DONE: begin
            if (rd_en) begin
              dout       <= mem[rd_ptr];
              dout_valid <= 1'b1;
              rd_ptr     <= rd_ptr + 1'b1;
              count      <= count - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state = state_q;
  assign empty = (count == '0);

endmodule

// File: doc/trace_capture_buffer.md
# trace_capture_buffer

Multi-channel, parametrised trace capture buffer for the NoC debug (DfD) path. It records one selected channel's trace samples into a circular single-port-write / single-port-read RAM. A trigger FSM supports pre-trigger and post-trigger capture windows. Once capture stops, the buffer freezes and is drained oldest-first by the JTAG read-out logic through a one-word-per-request read port.

## Interface
- `Fpay`, 32: width of one channel's trace word.
- `TB_Depth`, 512: buffer entries; must be a power of 2, ≥4.
- `CH`, 4: number of trace channels, ≥1.
- `AW`, `$clog2(TB_Depth)`: derived pointer width; not overridden.
- `SW`, `max(1,$clog2(CH))`: derived channel-select width.

- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `trace` in CH*Fpay: channel c occupies `[c*Fpay +: Fpay]`.
- `trace_valid` in CH: per-channel sample strobe.
- `ch_sel` in SW: channel to record; latched on `arm`.
- `post_len` in AW+1: samples to record after trigger; latched on `arm`, clipped to TB_Depth.
- `arm` in 1: one-cycle pulse that starts or restarts capture.
- `trigger` in 1: trigger event; level-sampled each cycle.
- `rd` in 1: read request, one word per asserted cycle.
- `dout` out Fpay: read data.
- `dout_valid` out 1: `dout` holds a valid word this cycle.
- `empty` out 1: `count == 0`.
- `wrapped` out 1: oldest data has been overwritten.
- `state` out 2: FSM state encoding.
- `count` out AW+1: entries currently held or remaining to read.

## Operation
- FSM states: IDLE=0, ARMED=1, POST=2, DONE=3.
- `arm` in any state:
  - next state ARMED;
  - `wr_ptr`, `rd_ptr`, `count`, `wrapped` cleared;
  - `ch_sel` and `post_len` latched.
  - `arm` has priority over `trigger` and `rd` in the same cycle.
- Write condition (ARMED or POST): `trace_valid[sel]` high writes `trace[sel]` to `mem[wr_ptr]`, then `wr_ptr` increments mod TB_Depth.
  - `count` increments, saturating at TB_Depth.
  - A write while `count == TB_Depth` sets `wrapped` (sticky until `arm`/`reset`).
- ARMED + `trigger`:
  - a valid sample in the trigger cycle is written and counts as pre-trigger;
  - if latched `post_len == 0`, go to DONE; otherwise go to POST with `remain = post_len`.
- POST: each write decrements `remain`; the write that takes `remain` to 0 moves the FSM to DONE. `trigger` is ignored.
- DONE: writes are blocked.
  - On entry, `rd_ptr` = `wrapped ? wr_ptr_next : 0`, i.e. the oldest entry.
  - `rd` with `count > 0`: read `mem[rd_ptr]`, `rd_ptr` increments mod TB_Depth, `count` decrements.
  - `rd` with `count == 0` is ignored; no `dout_valid`.
- `rd` outside DONE is ignored.
- `trigger` outside ARMED is ignored.
- IDLE: no writes; leaves IDLE only on `arm`.
- `reset` mid-operation: FSM to IDLE, all registers and outputs to reset values. RAM contents are not cleared.

## Timing
- Reset values: `dout=0`, `dout_valid=0`, `empty=1`, `wrapped=0`, `state=0`, `count=0`.
- Write: sample in cycle N is stored at the edge ending N; `count` is visible updated in N+1.
- FSM transitions take effect at the edge; `state` reflects the new state next cycle.
- Read latency is 1 cycle:
  - `rd` in cycle N gives `dout` and `dout_valid=1` in N+1;
  - back-to-back `rd` gives one word per cycle;
  - `dout_valid` is low whenever no read was accepted the previous cycle;
  - `dout` holds its last value.
- `empty` and `count` update in the cycle after the accepted read.
- Post-trigger window: DONE is entered at the edge of the `post_len`-th valid sample after trigger, or at the trigger edge when `post_len == 0`.

## Test plan
- Basic window: TB_Depth=512, `arm` with `ch_sel=2`, `post_len=4`; ch2 samples 0..9 in consecutive cycles, `trigger` with sample 5 -> DONE after sample 9, `count=10`, `wrapped=0`; 10 `rd` cycles return 0..9 in order, each 1 cycle after `rd`; `empty=1` after the last.
- Wrap: TB_Depth=8, `post_len=2`, samples 0..19, `trigger` with sample 17 -> DONE after 19, `wrapped=1`, `count=8`; read-out returns 12..19.
- Channel filter: ch0 and ch1 valid simultaneously with distinct data, `ch_sel=1` -> only ch1 words stored; `count` equals ch1 sample count.
- Zero post-length: `post_len=0`, `trigger` together with valid sample 0xA5 -> DONE next cycle, `count=1`, read returns 0xA5.
- Ignored requests and re-arm:
  - `rd` while ARMED and `rd` in DONE with `count=0` -> no `dout_valid`, pointers unchanged;
  - `trigger` in POST ignored;
  - `arm` in DONE with `count=5` -> ARMED, `count=0`, `empty=1`.
- Reset mid-POST: assert `reset` asynchronously with `remain=3` -> outputs immediately at reset values, `state=IDLE`; following `rd` gives no `dout_valid`; further samples are not stored until `arm`.
